snk_final_mixer: RTL and testbench
==================================

# snk_final_mixer

Parametrised final-video stage for the SNK triple-Z80 cores. It resolves a fixed-priority stack of up to four graphics layers with per-layer transparency and software layer masking, then looks the winning colour index up in a downloadable 3×4-bit palette. It produces registered, blanked RGB. It sits after the line buffer, side and background layer generators and drives the video output directly, replacing the per-game hard-wired priority logic.

## Interface
Parameters:
- NUM_LAYERS, 3: number of layers (2..4); index 0 has highest priority.
- LAYER_W, 8: pixel index width per layer.
- PAL_ADDR_W, 10: palette address width; BANK_W = PAL_ADDR_W − LAYER_W (≥1).
- PEN_W, 3: low pixel bits tested for transparency.
- TRANS_PEN, 3'b111: pen value meaning transparent.
- LAYER_BANKS, {2'd2,2'd1,2'd0}: packed NUM_LAYERS×BANK_W palette bank per layer; layer i uses slice i.
- BACKDROP_IDX, 10'h000: palette address used when no layer is opaque.
- PAL_BASE, 25'h80_000: download base; R, G, B planes at PAL_BASE + k·2^PAL_ADDR_W, k = 0, 1, 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  pixel clock enable; one pixel per cen.
- layer_data  in  NUM_LAYERS×LAYER_W  packed pixel indices, layer i at [i·LAYER_W +: LAYER_W].
- layer_en  in  NUM_LAYERS  per-layer enable; 0 forces the layer transparent.
- disp  in  1  display enable; 0 blanks the pixel.
- ioctl_addr  in  25  download address.
- ioctl_data  in  8  download data; only [3:0] is used.
- ioctl_wr  in  1  download write strobe.
- R, G, B  out  4 each  final colour.

## Operation
- Pipeline stages advance only on clk edges with cen=1. All stage registers hold when cen=0.
- S1 latches layer_data, layer_en and disp.
- S2 performs priority resolve:
  - Layer i is opaque when layer_en[i]=1 and pixel[PEN_W−1:0] ≠ TRANS_PEN.
  - The lowest-index opaque layer wins.
  - pal_addr = {LAYER_BANKS[i], pixel_i}.
  - If no layer is opaque, pal_addr = BACKDROP_IDX.
  - disp is carried alongside.
- S3 performs the palette read: three 2^PAL_ADDR_W × 4 synchronous RAMs are read at pal_addr; the registered nibbles and disp are carried.
- S4 is the output register: {R,G,B} = disp ? palette : 12'h000.
- Palette write:
  - Occurs on any clk edge with ioctl_wr=1 and ioctl_addr inside a plane window, independent of cen.
  - Address within the plane = ioctl_addr − plane base.
  - Addresses outside all three windows are ignored.
- Read and write of the same palette entry in the same cycle returns the old data.
- Palette contents are not cleared by rst; after power-up they are undefined until downloaded.

## Timing
- Latency: a pixel sampled on cen tick k appears on R/G/B after cen tick k+3 (4 register stages), i.e. valid from the clk edge of the 4th cen.
- Reset: all pipeline registers clear; R=G=B=0, and disp is treated as 0 in every stage. The first non-blank output appears after 4 cen ticks following rst deassertion.
- rst asserted mid-frame clears the pipeline on the next clk edge regardless of cen; in-flight pixels are lost.
- cen held low freezes the outputs at their last value; no pixel is dropped or duplicated.
- disp=0 on tick k blanks exactly the output of tick k+3; neighbouring pixels are unaffected.
- All layers disabled (layer_en=0) behaves identically to all layers transparent.

## Configuration
- FINALMIX_FADE_EN defined:
  - Adds input fade (4 bits) and an S5 stage between palette read and output.
  - Each channel output = max(channel − fade, 0), saturating.
  - fade is sampled in S4 alongside the pixel.
  - Latency becomes 5 cen ticks; reset clears S5 to 0.
- FINALMIX_FADE_EN undefined: no fade port, 4-tick latency, and no subtractor is synthesised.

## Test plan
- Reset: assert rst with cen toggling and disp=1 → R/G/B=0 throughout, and the first non-zero output appears exactly 4 cen ticks after release.
- Priority (default parameters):
  - Download R plane entry 0x005 = 4'hA.
  - Drive layer0=8'h05 and layer1=8'h11, both enabled.
  - Expected: R=4'hA after 4 cen ticks.
  - Then set layer0=8'h07 (transparent pen): the address switches to {2'd1,8'h11}=0x111, and R shows the R-plane value at 0x111.
- Layer mask: layer0 opaque with layer_en=3'b110 → layer1 wins. With all layers transparent, the output equals the palette value at BACKDROP_IDX.
- Blanking: palette at the selected address = 12'hFFF; drop disp for one cen tick → exactly one output pixel is 12'h000, with neighbours 12'hFFF.
- cen stall and download:
  - Hold cen=0 for 10 cycles mid-stream → the output holds and the sequence resumes unchanged afterwards.
  - Write ioctl_addr=PAL_BASE+0x400+0x005 with data 8'h3C → G at address 0x005 becomes 4'hC.
  - A write at PAL_BASE+0xC00 is ignored.
- Fade (FINALMIX_FADE_EN): colour 12'h8F2 with fade=4'h3 → output 12'h5C0 after 5 cen ticks. With fade=0 the output equals the palette value.

Source files
------------

// File: rtl/snk_final_mixer.sv
// snk_final_mixer: final video stage for the SNK triple-Z80 cores.
// Fixed-priority layer resolve with per-layer transparency and masking,
// downloadable 3x4-bit palette lookup, registered and blanked RGB output.
// Optional build macro FINALMIX_FADE_EN adds a saturating fade stage (S5).
module snk_final_mixer #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned LAYER_W    = 8,
  parameter int unsigned PAL_ADDR_W = 10,
  parameter int unsigned PEN_W      = 3,
  parameter logic [PEN_W-1:0] TRANS_PEN = 3'b111,
  parameter logic [NUM_LAYERS*(PAL_ADDR_W-LAYER_W)-1:0] LAYER_BANKS = {2'd2, 2'd1, 2'd0},
  parameter logic [PAL_ADDR_W-1:0] BACKDROP_IDX = 10'h000,
  parameter logic [24:0] PAL_BASE = 25'h80_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic [NUM_LAYERS*LAYER_W-1:0] layer_data,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          disp,
`ifdef FINALMIX_FADE_EN
  input  logic [3:0]                    fade,
`endif
  input  logic [24:0]                   ioctl_addr,
  input  logic [7:0]                    ioctl_data,
  input  logic                          ioctl_wr,
  output logic [3:0]                    R,
  output logic [3:0]                    G,
  output logic [3:0]                    B
);

  localparam int unsigned BANK_W   = PAL_ADDR_W - LAYER_W;
  localparam int unsigned PAL_SIZE = 1 << PAL_ADDR_W;
  localparam int unsigned PLANES   = 3;

  // ---------------------------------------------------------------------------
  // Palette download decode: three consecutive plane windows above PAL_BASE
  // ---------------------------------------------------------------------------
  logic [24:0]           dl_off_c;
  logic                  dl_in_win_c;
  logic [1:0]            dl_plane_c;
  logic [PAL_ADDR_W-1:0] dl_idx_c;
  logic                  we_r_c;
  logic                  we_g_c;
  logic                  we_b_c;
  logic                  unused_c;

  assign dl_off_c    = ioctl_addr - PAL_BASE;
  assign dl_in_win_c = (ioctl_addr >= PAL_BASE) && (dl_off_c < 25'(PLANES * PAL_SIZE));
  assign dl_plane_c  = dl_off_c[PAL_ADDR_W +: 2];
  assign dl_idx_c    = dl_off_c[PAL_ADDR_W-1:0];
  assign we_r_c      = ioctl_wr && dl_in_win_c && (dl_plane_c == 2'd0);
  assign we_g_c      = ioctl_wr && dl_in_win_c && (dl_plane_c == 2'd1);
  assign we_b_c      = ioctl_wr && dl_in_win_c && (dl_plane_c == 2'd2);
  // Palette entries are 4 bits wide; the upper download nibble is discarded.
  assign unused_c    = ^ioctl_data[7:4];

  // ---------------------------------------------------------------------------
  // S1: input capture
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS*LAYER_W-1:0] layer_q;
  logic [NUM_LAYERS-1:0]         en_q;
  logic                          disp1_q;

  // Latch the raw layer pixels, enables and display flag on each pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q <= '0;
      en_q    <= '0;
      disp1_q <= 1'b0;
    end else if (cen) begin
      layer_q <= layer_data;
      en_q    <= layer_en;
      disp1_q <= disp;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: priority resolve
  // ---------------------------------------------------------------------------
  logic [PAL_ADDR_W-1:0] pal_addr_d;
  logic [PAL_ADDR_W-1:0] pal_addr_q;
  logic                  disp2_q;
  logic [LAYER_W-1:0]    pix_c;
  logic                  found_c;

  // Scan from highest priority (index 0); first opaque, enabled layer wins.
  always_comb begin
    pal_addr_d = BACKDROP_IDX;
    found_c    = 1'b0;
    pix_c      = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      pix_c = layer_q[i*LAYER_W +: LAYER_W];
      if (!found_c && en_q[i] && (pix_c[PEN_W-1:0] != TRANS_PEN)) begin
        pal_addr_d = {LAYER_BANKS[i*BANK_W +: BANK_W], pix_c};
        found_c    = 1'b1;
      end
    end
  end

  // Register the resolved palette address with its display flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_addr_q <= '0;
      disp2_q    <= 1'b0;
    end else if (cen) begin
      pal_addr_q <= pal_addr_d;
      disp2_q    <= disp1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: palette RAMs (contents survive reset; read returns pre-write data)
  // ---------------------------------------------------------------------------
  logic [3:0] pal_r [0:PAL_SIZE-1];
  logic [3:0] pal_g [0:PAL_SIZE-1];
  logic [3:0] pal_b [0:PAL_SIZE-1];
  logic [3:0] rd_r_q;
  logic [3:0] rd_g_q;
  logic [3:0] rd_b_q;
  logic       disp3_q;

  // Download port: writes land whenever the strobe hits a plane window.
  always_ff @(posedge clk) begin
    if (we_r_c) pal_r[dl_idx_c] <= ioctl_data[3:0];
    if (we_g_c) pal_g[dl_idx_c] <= ioctl_data[3:0];
    if (we_b_c) pal_b[dl_idx_c] <= ioctl_data[3:0];
  end

  // Synchronous read port, advancing with the pixel pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r_q  <= '0;
      rd_g_q  <= '0;
      rd_b_q  <= '0;
      disp3_q <= 1'b0;
    end else if (cen) begin
      rd_r_q  <= pal_r[pal_addr_q];
      rd_g_q  <= pal_g[pal_addr_q];
      rd_b_q  <= pal_b[pal_addr_q];
      disp3_q <= disp2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S4: blanking register (and S5 fade when enabled)
  // ---------------------------------------------------------------------------
  logic [11:0] rgb4_d;

  assign rgb4_d = disp3_q ? {rd_r_q, rd_g_q, rd_b_q} : 12'h000;

`ifdef FINALMIX_FADE_EN
  logic [11:0] rgb4_q;
  logic [3:0]  fade_q;
  logic [3:0]  r5_d;
  logic [3:0]  g5_d;
  logic [3:0]  b5_d;

  // Blanked colour plus the fade amount that applies to this pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb4_q <= '0;
      fade_q <= '0;
    end else if (cen) begin
      rgb4_q <= rgb4_d;
      fade_q <= fade;
    end
  end

  // Saturating per-channel subtract, floor at zero.
  always_comb begin
    r5_d = 4'h0;
    g5_d = 4'h0;
    b5_d = 4'h0;
    if (rgb4_q[11:8] >= fade_q) r5_d = rgb4_q[11:8] - fade_q;
    if (rgb4_q[7:4]  >= fade_q) g5_d = rgb4_q[7:4]  - fade_q;
    if (rgb4_q[3:0]  >= fade_q) b5_d = rgb4_q[3:0]  - fade_q;
  end

  // Faded output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else if (cen) begin
      R <= r5_d;
      G <= g5_d;
      B <= b5_d;
    end
  end
`else
  // Final output register with blanking applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else if (cen) begin
      R <= rgb4_d[11:8];
      G <= rgb4_d[7:4];
      B <= rgb4_d[3:0];
    end
  end
`endif

endmodule

// File: tb/tb_snk_final_mixer.sv
// Directed bench for snk_final_mixer (default parameters, fade disabled).
// Expected colours are pushed to a queue per pixel tick and popped when the
// pixel reaches R/G/B four ticks later.
module tb_snk_final_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [23:0] layer_data;
  logic [2:0]  layer_en;
  logic        disp;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [3:0]  R;
  logic [3:0]  G;
  logic [3:0]  B;

  always #5 clk = ~clk;

  snk_final_mixer dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .layer_data (layer_data),
    .layer_en   (layer_en),
    .disp       (disp),
    .ioctl_addr (ioctl_addr),
    .ioctl_data (ioctl_data),
    .ioctl_wr   (ioctl_wr),
    .R          (R),
    .G          (G),
    .B          (B)
  );

  // Reference palette, only entries written by the bench are meaningful.
  logic [3:0]  mr [0:1023];
  logic [3:0]  mg [0:1023];
  logic [3:0]  mb [0:1023];
  logic [11:0] exp_q [$];
  logic [11:0] last_exp;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [11:0] model_rgb(input logic [23:0] d, input logic [2:0] en,
                                            input logic dsp);
    logic [9:0] a;
    if (en[0] && d[2:0] != 3'b111)        a = {2'd0, d[7:0]};
    else if (en[1] && d[10:8] != 3'b111)  a = {2'd1, d[15:8]};
    else if (en[2] && d[18:16] != 3'b111) a = {2'd2, d[23:16]};
    else                                  a = 10'h000;
    return dsp ? {mr[a], mg[a], mb[a]} : 12'h000;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One pixel tick: drive, push expectation, compare whatever emerges.
  task automatic tick(input logic [23:0] d, input logic [2:0] en, input logic dsp,
                      input string tag);
    @(negedge clk);
    layer_data = d;
    layer_en   = en;
    disp       = dsp;
    cen        = 1'b1;
    exp_q.push_back(model_rgb(d, en, dsp));
    @(posedge clk);
    #1;
    if (exp_q.size() >= 4) begin
      last_exp = exp_q.pop_front();
      check(tag, {R, G, B}, last_exp);
    end
  endtask

  // cen low with garbage on the inputs; output must hold.
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cen        = 1'b0;
      layer_data = 24'($urandom);
      layer_en   = 3'($urandom);
      disp       = 1'($urandom);
      @(posedge clk);
      #1;
      check("stall_hold", {R, G, B}, last_exp);
    end
  endtask

  task automatic raw_wr(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    cen        = 1'b0;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic pal_wr(input int plane, input int idx, input logic [7:0] d);
    raw_wr(25'(32'h80000 + plane * 1024 + idx), d);
    case (plane)
      0:       mr[idx] = d[3:0];
      1:       mg[idx] = d[3:0];
      default: mb[idx] = d[3:0];
    endcase
  endtask

  task automatic restart_queue();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(12'h000);
    last_exp = 12'h000;
  endtask

  localparam logic [23:0] PIX_L0   = {8'h33, 8'h11, 8'h05};
  localparam logic [23:0] PIX_L1   = {8'h33, 8'h11, 8'h07};
  localparam logic [23:0] PIX_NONE = {8'h2F, 8'h1F, 8'h07};
  localparam logic [23:0] PIX_FFF  = {8'h0E, 8'h17, 8'h07};

  initial begin
    rst        = 1'b1;
    cen        = 1'b0;
    layer_data = '0;
    layer_en   = '0;
    disp       = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    ioctl_wr   = 1'b0;
    last_exp   = 12'h000;

    // Palette download while held in reset (palette is not reset-controlled).
    pal_wr(0, 10'h005, 8'h0A); pal_wr(1, 10'h005, 8'h01); pal_wr(2, 10'h005, 8'h02);
    pal_wr(0, 10'h111, 8'h05); pal_wr(1, 10'h111, 8'h06); pal_wr(2, 10'h111, 8'h07);
    pal_wr(0, 10'h000, 8'h03); pal_wr(1, 10'h000, 8'h04); pal_wr(2, 10'h000, 8'h09);
    pal_wr(0, 10'h20E, 8'hFF); pal_wr(1, 10'h20E, 8'hFF); pal_wr(2, 10'h20E, 8'hFF);

    // Reset with cen toggling and a visible pixel on the inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cen        = ~cen;
      disp       = 1'b1;
      layer_en   = 3'b111;
      layer_data = PIX_L0;
      @(posedge clk);
      #1;
      check("reset_zero", {R, G, B}, 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b0;
    restart_queue();

    // Priority: first three ticks still zero, first pixel on the 4th tick.
    tick(PIX_L0, 3'b111, 1'b1, "prio_l0");
    tick(PIX_L0, 3'b111, 1'b1, "prio_l0");
    tick(PIX_L1, 3'b111, 1'b1, "prio_l1");
    tick(PIX_L0, 3'b110, 1'b1, "mask_l0");
    tick(PIX_NONE, 3'b111, 1'b1, "backdrop");
    tick(PIX_L0, 3'b000, 1'b1, "all_off");
    tick(PIX_FFF, 3'b111, 1'b1, "blank_pre");
    tick(PIX_FFF, 3'b111, 1'b1, "blank_pre");
    tick(PIX_FFF, 3'b111, 1'b0, "blank_hole");
    tick(PIX_FFF, 3'b111, 1'b1, "blank_post");
    tick(PIX_FFF, 3'b111, 1'b1, "blank_post");
    tick(PIX_L1, 3'b111, 1'b1, "seq_a");
    tick(PIX_L0, 3'b111, 1'b1, "seq_b");
    tick(PIX_NONE, 3'b111, 1'b1, "seq_c");

    // Stall mid-stream, then resume.
    stall(10);
    tick(PIX_FFF, 3'b111, 1'b1, "resume_a");
    tick(PIX_L1, 3'b111, 1'b1, "resume_b");
    tick(PIX_L0, 3'b111, 1'b1, "resume_c");
    tick(PIX_NONE, 3'b111, 1'b1, "resume_d");

    // Drain with blank pixels before touching the palette.
    tick(PIX_L0, 3'b111, 1'b0, "drain");
    tick(PIX_L0, 3'b111, 1'b0, "drain");
    tick(PIX_L0, 3'b111, 1'b0, "drain");

    // G plane write via window 1, plus writes outside every window.
    pal_wr(1, 10'h005, 8'h3C);
    raw_wr(25'h80C00, 8'h0F);
    raw_wr(25'h80C05, 8'h0F);
    raw_wr(25'h81005, 8'h00);
    raw_wr(25'h7F805, 8'h00);
    tick(PIX_L0, 3'b111, 1'b1, "dl_g");
    tick(PIX_NONE, 3'b111, 1'b1, "dl_backdrop");
    tick(PIX_L1, 3'b111, 1'b1, "dl_l1");
    tick(PIX_L0, 3'b111, 1'b1, "dl_g");
    tick(PIX_L0, 3'b111, 1'b1, "dl_g");
    tick(PIX_NONE, 3'b111, 1'b1, "dl_backdrop");
    tick(PIX_L1, 3'b111, 1'b1, "dl_l1");

    // Reset mid-stream with cen low: clears on that edge.
    @(negedge clk);
    rst = 1'b1;
    cen = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_zero", {R, G, B}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    restart_queue();
    tick(PIX_L0, 3'b111, 1'b1, "post_rst");
    tick(PIX_L1, 3'b111, 1'b1, "post_rst");
    tick(PIX_FFF, 3'b111, 1'b1, "post_rst");
    tick(PIX_NONE, 3'b111, 1'b1, "post_rst");
    tick(PIX_L0, 3'b111, 1'b1, "post_rst");
    tick(PIX_L0, 3'b011, 1'b1, "post_rst");
    tick(PIX_L0, 3'b111, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
